// File: rtl/rice_word_loader.sv
// Two-word {cur,nxt} window loader for the Rice decoder: buffers FIFO words,
// retires one per carry, and presents a registered bit-aligned 32-bit window.
module rice_word_loader #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              cout,
  input  logic [LEN_W-1:0]  remlendup,
  output logic              ldor,
  output logic [WORD_W-1:0] win_data,
  output logic              win_valid,
  output logic              underrun,
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [1:0] {EMPTY, HALF, FULL, REFILL} state_t;

  state_t            state_q;
  logic [WORD_W-1:0] cur_q;
  logic [WORD_W-1:0] nxt_q;
  logic [WORD_W-1:0] win_data_q;
  logic [WORD_W-1:0] win_data_d;
  logic              win_valid_q;
  logic              ldor_q;
  logic              underrun_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              xfer;
  logic [LEN_W:0]    rshamt;

  assign s_ready = reset && ((state_q != FULL) || cout);
  assign xfer    = s_valid && s_ready;

  // Upper half of {cur,nxt} << offset; a right shift by WORD_W yields zero,
  // so offset 0 gives cur unchanged.
  assign rshamt     = (LEN_W+1)'(WORD_W) - {1'b0, remlendup};
  assign win_data_d = (cur_q << remlendup) | (nxt_q >> rshamt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= EMPTY;
      cur_q       <= '0;
      nxt_q       <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      ldor_q      <= 1'b0;
      underrun_q  <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      ldor_q      <= 1'b0;
      win_data_q  <= win_data_d;
      win_valid_q <= (state_q == FULL) && !cout;
      case (state_q)
        EMPTY: begin
          if (xfer) begin
            cur_q   <= s_data;
            state_q <= HALF;
          end
          if (cout) underrun_q <= 1'b1;
        end
        HALF: begin
          if (xfer) begin
            nxt_q   <= s_data;
            state_q <= FULL;
            ldor_q  <= 1'b1;
          end
          if (cout) underrun_q <= 1'b1;
        end
        FULL: begin
          if (cout) begin
            cur_q      <= nxt_q;
            word_cnt_q <= word_cnt_q + CNT_W'(1);
            if (xfer) nxt_q <= s_data;
            else      state_q <= REFILL;
          end
        end
        REFILL: begin
          // carrygenerator is already running here, so no ldor pulse
          if (xfer) begin
            nxt_q   <= s_data;
            state_q <= FULL;
          end
          if (cout) underrun_q <= 1'b1;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign ldor      = ldor_q;
  assign win_data  = win_data_q;
  assign win_valid = win_valid_q;
  assign underrun  = underrun_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_rice_word_loader.sv
// Scoreboarded bench for rice_word_loader: expected windows are queued by the
// stimulus and checked by a monitor on every valid window.
module tb_rice_word_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        cout;
  logic [4:0]  remlendup;
  logic        ldor;
  logic [31:0] win_data;
  logic        win_valid;
  logic        underrun;
  logic [15:0] word_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rice_word_loader #(.WORD_W(32), .LEN_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cout(cout), .remlendup(remlendup), .ldor(ldor),
    .win_data(win_data), .win_valid(win_valid), .underrun(underrun),
    .word_cnt(word_cnt)
  );

  // Monitor: every valid window must match the next queued expectation.
  always @(negedge clk) begin
    if (win_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL win_unexpected: win_valid=1 win_data=%08h, required no window", win_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (win_data !== e) begin
          n_fail++;
          $display("FAIL win_data: got %08h, required %08h", win_data, e);
        end else begin
          $display("window ok: %08h", win_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end else begin
      $display("check ok: %s = %08h", name, act);
    end
  endtask

  // Combinational s_ready check after inputs have settled
  task automatic chk_ready(input string name, input logic exp);
    #1;
    chk(name, {31'd0, s_ready}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; cout = 1'b0; remlendup = '0;
    #1;
    repeat (3) step();
    chk_ready("s_ready_in_reset", 1'b0);
    reset = 1'b1;
    // EMPTY after release
    chk_ready("s_ready_after_reset", 1'b1);
    chk("win_valid_reset", {31'd0, win_valid}, 32'd0);
    chk("ldor_reset", {31'd0, ldor}, 32'd0);
    chk("underrun_reset", {31'd0, underrun}, 32'd0);
    chk("word_cnt_reset", {16'd0, word_cnt}, 32'd0);

    // Prime: A5A5_0000 then 1234_5678
    s_valid = 1'b1; s_data = 32'hA5A5_0000;
    step();
    s_data = 32'h1234_5678;
    chk("ldor_half", {31'd0, ldor}, 32'd0);
    step();
    s_valid = 1'b0;
    chk("ldor_pulse", {31'd0, ldor}, 32'd1);
    step();
    chk("ldor_single", {31'd0, ldor}, 32'd0);
    exp_q.push_back(32'hA5A5_0000);
    remlendup = 5'd8;
    step();
    exp_q.push_back(32'hA500_0012);

    // Advance with simultaneous refill
    cout = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    chk_ready("s_ready_full_cout", 1'b1);
    step();
    cout = 1'b0; s_valid = 1'b0; remlendup = 5'd0;
    chk("word_cnt_1", {16'd0, word_cnt}, 32'd1);
    step();
    exp_q.push_back(32'h1234_5678);
    remlendup = 5'd16;
    step();
    exp_q.push_back(32'h5678_DEAD);

    // Advance without refill -> REFILL
    cout = 1'b1; remlendup = 5'd0;
    step();
    cout = 1'b0;
    chk("word_cnt_2", {16'd0, word_cnt}, 32'd2);
    s_valid = 1'b1; s_data = 32'hCAFE_F00D;
    chk_ready("s_ready_refill", 1'b1);
    step();
    s_valid = 1'b0; remlendup = 5'd4;
    chk("ldor_refill", {31'd0, ldor}, 32'd0);
    step();
    exp_q.push_back(32'hEADB_EEFC);
    chk("ldor_after_refill", {31'd0, ldor}, 32'd0);
    remlendup = 5'd0;
    step();
    exp_q.push_back(32'hDEAD_BEEF);

    // Retire into REFILL, then cout in REFILL -> underrun
    cout = 1'b1;
    step();
    chk("word_cnt_3", {16'd0, word_cnt}, 32'd3);
    chk_ready("s_ready_refill2", 1'b1);
    step();
    cout = 1'b0;
    chk("underrun_set", {31'd0, underrun}, 32'd1);
    chk("word_cnt_hold", {16'd0, word_cnt}, 32'd3);
    step();
    chk("underrun_sticky", {31'd0, underrun}, 32'd1);
    s_valid = 1'b1; s_data = 32'h0BAD_F00D;
    step();
    s_valid = 1'b0; remlendup = 5'd31;
    step();
    exp_q.push_back(32'h85D6_F806);
    chk("underrun_sticky2", {31'd0, underrun}, 32'd1);

    // Reset mid-stream with a FIFO word on offer
    reset = 1'b0; s_valid = 1'b1; s_data = 32'h1111_1111; remlendup = 5'd0;
    chk_ready("s_ready_reset_mid", 1'b0);
    step();
    reset = 1'b1;
    chk("word_cnt_after_rst", {16'd0, word_cnt}, 32'd0);
    chk("underrun_after_rst", {31'd0, underrun}, 32'd0);
    chk("win_valid_after_rst", {31'd0, win_valid}, 32'd0);
    s_data = 32'h2222_2222;
    step();
    s_data = 32'h3333_3333;
    step();
    s_valid = 1'b0;
    chk("ldor_reprime", {31'd0, ldor}, 32'd1);
    step();
    exp_q.push_back(32'h2222_2222);

    // Continuous advance for 2^16 carries -> word_cnt wraps to 0
    cout = 1'b1; s_valid = 1'b1; s_data = 32'h4444_4444;
    for (int i = 0; i < 65536; i++) step();
    cout = 1'b0; s_valid = 1'b0;
    chk("word_cnt_wrap", {16'd0, word_cnt}, 32'd0);
    step();
    exp_q.push_back(32'h4444_4444);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
